fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, default 4: number of write requesters.
- DATA_WIDTH, default 8: FIFO data width.
- CNT_WIDTH, default 16: grant-counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- PCLK  in  1  sole clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  8  APB byte address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot accept.
- wr_en  out  1  FIFO write strobe.
- wr_data  out  DATA_WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.

REQ-003 The block SHALL use one clock, PCLK; PRESETn SHALL be asynchronous and active-low.

Function
REQ-004 PREADY SHALL be constant 1; an APB access SHALL take effect when PSEL && PENABLE.

REQ-005 PRDATA SHALL be combinational during the access phase and 0 otherwise. The register map SHALL be:
- 0x00 CTRL (RW): bit0 EN, bit1 MODE (0 round-robin, 1 fixed priority), bits[7:4] BURST_LEN.
- 0x04 STATUS (RO): bit0 fifo_empty, bit1 fifo_full, bit2 in BURST, bits[9:8] owner index.
- 0x08+4*i GNT_CNT[i] (RO): zero-extended.
- 0x18 CLR (WO): writing 1 to bit i clears GNT_CNT[i].
- Reads of unmapped addresses SHALL return 32'hDEADBEEF.
- Writes to RO or unmapped addresses SHALL be ignored.

REQ-006 Handshake SHALL be same-cycle: a beat occurs for requester i when req_ready[i] && req_valid[i].
- req_ready SHALL be one-hot or zero.
- wr_en SHALL equal |(req_ready & req_valid).
- wr_data SHALL equal req_data of the granted requester, or 0 when there is no beat.

REQ-007 No beat SHALL occur while fifo_full=1 or EN=0.

REQ-008 The FSM SHALL have two states, IDLE and BURST.

REQ-009 IDLE behaviour:
- If EN=1, !fifo_full and any req_valid is set, the winner SHALL be granted one beat that cycle.
- MODE=1: the winner SHALL be the lowest valid index.
- MODE=0: the winner SHALL be the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.

REQ-010 Effective burst length L SHALL be BURST_LEN, with BURST_LEN=0 treated as 1.
- If L>1, the IDLE beat SHALL move the FSM to BURST with owner=winner and beats_left=L-1.
- Otherwise the FSM SHALL stay in IDLE and rr_ptr SHALL become (winner+1) mod NUM_REQ.

REQ-011 BURST behaviour:
- Only the owner SHALL be eligible.
- When owner valid && !fifo_full && EN: one beat per cycle, with beats_left decremented.
- The beat that takes beats_left to 0 SHALL return the FSM to IDLE and set rr_ptr=(owner+1) mod NUM_REQ.

REQ-012 In BURST with fifo_full=1, the FSM SHALL hold state, owner and beats_left and SHALL issue no beat.

REQ-013 In BURST, owner req_valid=0 or EN=0 SHALL return the FSM to IDLE on the next edge with no beat that cycle; rr_ptr SHALL become owner+1.

REQ-014 A CTRL write mid-burst SHALL NOT change the current burst; the new MODE and BURST_LEN SHALL apply from the next IDLE grant.

REQ-015 GNT_CNT[i] SHALL increment by 1 per beat of requester i.
- It SHALL saturate at 2^CNT_WIDTH-1.
- A CLR of the same bit in the same cycle as a beat SHALL win, giving 0.

REQ-016 rr_ptr SHALL be $clog2(NUM_REQ) bits wide and SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-017 While PRESETn=0, the following SHALL be held at 0: CTRL, all GNT_CNT, rr_ptr, owner and beats_left; the FSM SHALL be in IDLE.
- req_ready, wr_en and wr_data SHALL be 0 immediately, independent of PCLK.

REQ-018 Reset asserted mid-burst SHALL abort the burst with no further beat; after release, EN=0 SHALL hold all requesters off until CTRL is written.

Verification
REQ-019 RR fairness: CTRL=0x01, all four req_valid=1, fifo_full=0 -> grants 0,1,2,3,0 on consecutive cycles; each GNT_CNT=1 after four cycles.

REQ-020 Fixed priority: CTRL=0x03, req_valid=4'b1010 -> requester 1 granted every cycle; GNT_CNT[3] stays 0.

REQ-021 Burst with full stall: CTRL=0x31 (L=3), req_valid=4'b0101 -> sequence is:
- req 0 gets beat 1, then fifo_full=1 for 2 cycles (no wr_en, STATUS bit2=1).
- fifo_full=0 then gives req 0 beats 2 and 3.
- req 2 is granted next.

REQ-022 Owner drop: CTRL=0x41, req 1 drops valid after 2 of 4 beats -> one idle cycle, then rr_ptr=2 and arbitration resumes.

REQ-023 Counters: force GNT_CNT[0] to saturate (CNT_WIDTH=4, 20 beats) -> it reads 15; CLR=0x1 in the same cycle as a beat -> it reads 0.

REQ-024 APB and reset: read 0x20 -> 32'hDEADBEEF; a write to 0x04 has no effect; PRESETn pulsed mid-burst -> wr_en=0 asynchronously and CTRL reads 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Arbitrates NUM_REQ write requesters onto a single FIFO write port. The grant
// policy is either round-robin or fixed priority (lowest index wins). Optional
// bursts keep one requester as owner for BURST_LEN beats. A small APB slave
// provides control, status and per-requester saturating grant counters.
//
// Handshake is same-cycle: a beat happens when req_ready[i] && req_valid[i],
// and that beat drives wr_en/wr_data combinationally.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE  APB control
//   PADDR, PWDATA        APB byte address and write data
//   PRDATA, PREADY       APB read data (0 outside an access), ready (always 1)
//   req_valid, req_data  per-requester valid and packed data
//   req_ready            one-hot (or zero) accept
//   wr_en, wr_data       FIFO write strobe and data
//   fifo_full/empty      FIFO flags
//
// Register map
//   0x00 CTRL   RW  [0] EN, [1] MODE (1 = fixed priority), [7:4] BURST_LEN
//   0x04 STATUS RO  [0] fifo_empty, [1] fifo_full, [2] in burst, [9:8] owner
//   0x08+4*i    RO  GNT_CNT[i]
//   0x18 CLR    WO  write 1 to bit i to clear GNT_CNT[i]
//   other reads return 32'hDEADBEEF
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [7:0]                    PADDR,
  input  logic [31:0]                   PWDATA,
  output logic [31:0]                   PRDATA,
  output logic                          PREADY,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          fifo_full,
  input  logic                          fifo_empty
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CNT0   = 8'h08;
  localparam logic [7:0] ADDR_CLR    = 8'h18;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t               state_q, state_d;
  logic                 ctrl_en_q, ctrl_mode_q;
  logic [3:0]           ctrl_len_q;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [3:0]           beats_left_q, beats_left_d;
  logic [CNT_WIDTH-1:0] gnt_cnt_q [NUM_REQ];

  logic                 apb_access, apb_wr;
  logic [NUM_REQ-1:0]   clr_vec;
  logic [IDX_W-1:0]     winner, grant_idx, cand;
  logic                 any_valid, beat;
  logic [3:0]           eff_len;
  logic [1:0]           owner_field;
  logic                 unused_pwdata;

  assign PREADY     = 1'b1;
  assign apb_access = PSEL && PENABLE;
  assign apb_wr     = apb_access && PWRITE;
  assign clr_vec    = (apb_wr && PADDR == ADDR_CLR) ? PWDATA[NUM_REQ-1:0] : '0;
  assign eff_len    = (ctrl_len_q == 4'd0) ? 4'd1 : ctrl_len_q;
  assign owner_field = 2'(owner_q);
  // Only a few PWDATA bits land in registers; fold the rest away.
  assign unused_pwdata = ^PWDATA;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Candidate winner for an IDLE grant. Scanning from the far end lets the
  // last match (the nearest index) win without a break.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    winner    = '0;
    cand      = '0;
    any_valid = |req_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (ctrl_mode_q) cand = IDX_W'(k);
      else             cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) winner = cand;
    end
  end

  // Next-state / grant logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx    = winner;
    beat         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q && !fifo_full && any_valid) begin
          beat = 1'b1;
          if (eff_len > 4'd1) begin
            state_d      = ST_BURST;
            owner_d      = winner;
            beats_left_d = eff_len - 4'd1;
          end else begin
            rr_ptr_d = inc_idx(winner);
          end
        end
      end
      ST_BURST: begin
        grant_idx = owner_q;
        // Losing the owner (or EN) ends the burst without a beat; a full FIFO
        // merely stalls it with everything held.
        if (!ctrl_en_q || !req_valid[owner_q]) begin
          state_d      = ST_IDLE;
          beats_left_d = '0;
          rr_ptr_d     = inc_idx(owner_q);
        end else if (!fifo_full) begin
          beat         = 1'b1;
          beats_left_d = beats_left_q - 4'd1;
          if (beats_left_q == 4'd1) begin
            state_d  = ST_IDLE;
            rr_ptr_d = inc_idx(owner_q);
          end
        end
      end
    endcase
  end

  assign req_ready = beat ? (NUM_REQ'(1) << grant_idx) : '0;
  assign wr_en     = |(req_ready & req_valid);
  assign wr_data   = wr_en ? req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH] : '0;

  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      beats_left_q <= '0;
      rr_ptr_q     <= '0;
      ctrl_en_q    <= 1'b0;
      ctrl_mode_q  <= 1'b0;
      ctrl_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      rr_ptr_q     <= rr_ptr_d;
      if (apb_wr && PADDR == ADDR_CTRL) begin
        ctrl_en_q   <= PWDATA[0];
        ctrl_mode_q <= PWDATA[1];
        ctrl_len_q  <= PWDATA[7:4];
      end
    end
  end

  // Grant counters saturate; a clear in the same cycle as a beat wins.
  // NOTE: the counter array is software-visible, so it is reset like any other register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REQ; i++) gnt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (clr_vec[i])
          gnt_cnt_q[i] <= '0;
        else if (req_ready[i] && req_valid[i] && gnt_cnt_q[i] != '1)
          gnt_cnt_q[i] <= gnt_cnt_q[i] + 1'b1;
      end
    end
  end

  // APB read mux: combinational during the access phase, 0 otherwise.
  always_comb begin
    PRDATA = '0;
    if (apb_access) begin
      PRDATA = 32'hDEADBEEF;
      if (PADDR == ADDR_CTRL)
        PRDATA = {24'd0, ctrl_len_q, 2'b00, ctrl_mode_q, ctrl_en_q};
      if (PADDR == ADDR_STATUS)
        PRDATA = {22'd0, owner_field, 5'd0, (state_q == ST_BURST), fifo_full, fifo_empty};
      if (PADDR == ADDR_CLR)
        PRDATA = '0;
      for (int i = 0; i < NUM_REQ; i++)
        if (PADDR == 8'(ADDR_CNT0 + 4 * i)) PRDATA = 32'(gnt_cnt_q[i]);
    end
  end

endmodule
